// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard that stalls ID on RAW, WAW and MDU
// structural hazards and counts stalled cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Valid_i,
  input  logic [REG_ADDR_W-1:0] Rs1_i,
  input  logic [REG_ADDR_W-1:0] Rs2_i,
  input  logic                  Rs1Use_i,
  input  logic                  Rs2Use_i,
  input  logic [REG_ADDR_W-1:0] Rd_i,
  input  logic                  RegWrite_i,
  input  logic [1:0]            Class_i,
  input  logic                  Flush_i,
  output logic                  Stall_o,
  output logic                  PCWrite_o,
  output logic                  NoOp_o,
  output logic                  MDUBusy_o,
  output logic [CNT_W-1:0]      StallCnt_o
);
  localparam int MAX_LAT = LOAD_LAT > MDU_LAT ? LOAD_LAT : MDU_LAT;
  localparam int LAT_W = MAX_LAT > 1 ? $clog2(MAX_LAT + 1) : 1;
  localparam int NREG = 2 ** REG_ADDR_W;
  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] mdu_cnt, lat;
  logic [CNT_W-1:0] stall_cnt;
  logic raw, structural, waw, issue;
  always_comb begin
    lat = Class_i == 2'b01 ? LAT_W'(LOAD_LAT) : Class_i == 2'b10 ? LAT_W'(MDU_LAT) : '0;
    raw = (Rs1Use_i && Rs1_i != '0 && cnt[Rs1_i] != '0) ||
          (Rs2Use_i && Rs2_i != '0 && cnt[Rs2_i] != '0);
    structural = Class_i == 2'b10 && mdu_cnt != '0;
    waw = RegWrite_i && Rd_i != '0 && cnt[Rd_i] > lat;
    Stall_o = Valid_i && !Flush_i && (raw || structural || waw);
    issue = Valid_i && !Flush_i && !Stall_o;
  end
  assign PCWrite_o = !Stall_o;
  assign NoOp_o = Stall_o;
  assign MDUBusy_o = mdu_cnt != '0;
  assign StallCnt_o = stall_cnt;
  // cnt[0] is only ever reset, so x0 never looks busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      mdu_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        cnt[r] <= (issue && RegWrite_i && Rd_i == REG_ADDR_W'(r) && lat != '0) ? lat
                  : cnt[r] - LAT_W'(cnt[r] != '0);
      mdu_cnt <= (issue && Class_i == 2'b10) ? LAT_W'(MDU_LAT) : mdu_cnt - LAT_W'(mdu_cnt != '0);
      stall_cnt <= stall_cnt + CNT_W'(Stall_o && !(&stall_cnt));
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: two scoreboards (default and LOAD_LAT=3/CNT_W=4) driven in parallel
// and compared against a ready-time model, with directed hazard scenarios then random traffic.
module tb_hazard_scoreboard;
  logic clk = 0;
  logic rst, valid, rs1_use, rs2_use, reg_write, flush;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] cls;
  logic stall_o [2];
  logic pcw [2];
  logic noop [2];
  logic busy [2];
  logic [15:0] scnt0;
  logic [3:0] scnt1;
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut0 (
    .clk_i(clk), .rst_i(rst), .Valid_i(valid), .Rs1_i(rs1), .Rs2_i(rs2),
    .Rs1Use_i(rs1_use), .Rs2Use_i(rs2_use), .Rd_i(rd), .RegWrite_i(reg_write),
    .Class_i(cls), .Flush_i(flush), .Stall_o(stall_o[0]), .PCWrite_o(pcw[0]),
    .NoOp_o(noop[0]), .MDUBusy_o(busy[0]), .StallCnt_o(scnt0)
  );

  hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .Valid_i(valid), .Rs1_i(rs1), .Rs2_i(rs2),
    .Rs1Use_i(rs1_use), .Rs2Use_i(rs2_use), .Rd_i(rd), .RegWrite_i(reg_write),
    .Class_i(cls), .Flush_i(flush), .Stall_o(stall_o[1]), .PCWrite_o(pcw[1]),
    .NoOp_o(noop[1]), .MDUBusy_o(busy[1]), .StallCnt_o(scnt1)
  );

  // Model: absolute cycle at which each register / the MDU becomes free
  int ready [2][32];
  int mdu_free [2];
  int stalls [2];
  int k = 0;
  int load_lat [2] = '{1, 3};
  int smax [2] = '{65535, 15};
  bit chk_en = 0;
  bit s [2];
  bit b [2];

  function automatic int lat_of(int d);
    return cls == 2'b01 ? load_lat[d] : cls == 2'b10 ? 4 : 0;
  endfunction

  function automatic int rem(int d, int r);
    return ready[d][r] > k ? ready[d][r] - k : 0;
  endfunction

  function automatic bit m_stall(int d);
    if (!valid || flush) return 0;
    return (rs1_use && rs1 != 0 && rem(d, rs1) > 0) || (rs2_use && rs2 != 0 && rem(d, rs2) > 0) ||
           (cls == 2'b10 && mdu_free[d] > k) || (reg_write && rd != 0 && rem(d, rd) > lat_of(d));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set(input int v, input int r1, input int u1, input int r2, input int u2,
                     input int d, input int w, input int c, input int f);
    valid = 1'(v); rs1 = 5'(r1); rs1_use = 1'(u1); rs2 = 5'(r2); rs2_use = 1'(u2);
    rd = 5'(d); reg_write = 1'(w); cls = 2'(c); flush = 1'(f);
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit e [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) e[d] = m_stall(d);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("stall%0d", d), 32'(stall_o[d]), 32'(e[d]));
        chk($sformatf("pcwrite%0d", d), 32'(pcw[d]), 32'(!e[d]));
        chk($sformatf("noop%0d", d), 32'(noop[d]), 32'(e[d]));
        chk($sformatf("mdubusy%0d", d), 32'(busy[d]), 32'(mdu_free[d] > k));
      end
      chk("stallcnt0", 32'(scnt0), 32'(stalls[0]));
      chk("stallcnt1", 32'(scnt1), 32'(stalls[1]));
    end
    for (int d = 0; d < 2; d++) begin s[d] = stall_o[d]; b[d] = busy[d]; end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) ready[d][r] = 0;
        mdu_free[d] = 0;
        stalls[d] = 0;
      end else begin
        if (e[d] && stalls[d] < smax[d]) stalls[d]++;
        if (valid && !flush && !e[d]) begin
          if (reg_write && rd != 0 && lat_of(d) > 0) ready[d][rd] = k + 1 + lat_of(d);
          if (cls == 2'b10) mdu_free[d] = k + 1 + 4;
        end
      end
    end
    k++;
    #1;
  endtask

  task automatic hold(input string tag, input int e0, input int e1);
    int n0 = 0, n1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n0 += int'(s[0]);
      n1 += int'(s[1]);
      if (!s[0] && !s[1]) break;
    end
    chk({tag, "_stalls0"}, 32'(n0), 32'(e0));
    chk({tag, "_stalls1"}, 32'(n1), 32'(e1));
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  initial begin
    int nb0, nb1;
    rst = 1;
    set(1, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    // load-use: x5 loaded, consumer add x6,x5,x7
    set(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set(1, 5, 1, 7, 1, 6, 1, 0, 0); hold("load_use", 1, 3);
    chk("load_use_cnt0", 32'(scnt0), 32'd1);
    chk("load_use_cnt1", 32'(scnt1), 32'd3);
    drain();
    // MDU occupancy window
    set(1, 0, 0, 0, 0, 3, 1, 2, 0); tick();
    idle();
    nb0 = 0; nb1 = 0;
    repeat (8) begin tick(); nb0 += int'(b[0]); nb1 += int'(b[1]); end
    chk("mdu_busy_cycles0", 32'(nb0), 32'd4);
    chk("mdu_busy_cycles1", 32'(nb1), 32'd4);
    set(1, 0, 0, 0, 0, 3, 1, 2, 0); tick();
    set(1, 3, 1, 1, 1, 4, 1, 0, 0); hold("mdu_use", 4, 4);
    drain();
    set(1, 0, 0, 0, 0, 3, 1, 2, 0); tick();
    set(1, 1, 1, 2, 1, 8, 1, 2, 0); hold("mdu_struct", 4, 4);
    drain();
    // x0 and unused sources never stall
    set(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
    set(1, 0, 1, 0, 1, 6, 1, 0, 0); hold("x0_use", 0, 0);
    set(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();
    set(1, 1, 1, 9, 0, 6, 1, 0, 0); hold("unused_rs2", 0, 0);
    drain();
    // WAW: mul x3 then lw x3, then a use of x3
    set(1, 0, 0, 0, 0, 3, 1, 2, 0); tick();
    set(1, 0, 0, 0, 0, 3, 1, 1, 0); hold("waw", 3, 1);
    set(1, 3, 1, 0, 0, 4, 1, 0, 0); hold("waw_use", 1, 3);
    drain();
    // flush during a load-use stall
    set(1, 0, 0, 0, 0, 5, 1, 1, 0); tick();
    set(1, 5, 1, 0, 0, 6, 1, 0, 1); tick();
    chk("flush_stall0", 32'(s[0]), 32'd0);
    chk("flush_stall1", 32'(s[1]), 32'd0);
    idle(); repeat (3) tick();
    set(1, 5, 1, 0, 0, 6, 1, 0, 0); hold("flush_drain", 0, 0);
    // saturation: back-to-back MDU ops from a clean reset
    rst = 1; idle(); tick(); rst = 0;
    set(1, 0, 0, 0, 0, 3, 1, 2, 0);
    repeat (25) tick();
    chk("sat_cnt0", 32'(scnt0), 32'd20);
    chk("sat_cnt1", 32'(scnt1), 32'd15);
    drain();
    // reset while stalled
    set(1, 0, 0, 0, 0, 3, 1, 2, 0); tick();
    set(1, 3, 1, 0, 0, 4, 1, 0, 0); tick();
    rst = 1; tick();
    rst = 0; tick();
    chk("post_reset_stall0", 32'(s[0]), 32'd0);
    chk("post_reset_stall1", 32'(s[1]), 32'd0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      set(int'($urandom_range(7) != 0), $urandom_range(7), $urandom_range(1), $urandom_range(7),
          $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(3),
          int'($urandom_range(7) == 0));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
